// File: rtl/bk_serial_subtractor.sv
// Digit-serial operand recovery for the Brent-Kung adder: opb = (sum - opa) mod 2^WIDTH, range_err when S-A leaves [0, 2^WIDTH-1].
// Optional macro BK_SUB_ADDMODE_EN adds a 'mode' port (1 = subtract, 0 = add); latency is WIDTH/DIGIT+1 edges from accept.
module bk_serial_subtractor #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] opa,
`ifdef BK_SUB_ADDMODE_EN
  input  logic             mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] opb,
  output logic             range_err
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("bk_serial_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_sum;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_borrow;
  logic             r_range_err;
  logic [CW-1:0]    r_idx;
  logic             w_last;
  logic [DIGIT-1:0] w_s_dig;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_dig;
  logic             w_cy;
  logic             w_err;
  logic [DIGIT:0]   w_sub_res;

  assign w_last  = (r_idx == CW'(NDIG - 1));
  assign w_s_dig = r_sum[r_idx*DIGIT +: DIGIT];
  assign w_a_dig = r_opa[r_idx*DIGIT +: DIGIT];

  // MSB of the (DIGIT+1)-bit difference is set exactly when the digit went negative.
  assign w_sub_res = {1'b0, w_s_dig} - {1'b0, w_a_dig} - {{DIGIT{1'b0}}, r_borrow};

`ifdef BK_SUB_ADDMODE_EN
  logic           r_mode;
  logic [DIGIT:0] w_add_res;
  assign w_add_res   = {1'b0, w_s_dig} + {1'b0, w_a_dig} + {{DIGIT{1'b0}}, r_borrow};
  assign {w_cy, w_dig} = r_mode ? w_sub_res : w_add_res;
  assign w_err       = r_mode ? (r_sum[WIDTH] != w_cy) : (w_cy | r_sum[WIDTH]);
`else
  assign {w_cy, w_dig} = w_sub_res;
  assign w_err       = (r_sum[WIDTH] != w_cy);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_borrow    <= 1'b0;
      r_range_err <= 1'b0;
      r_idx       <= '0;
`ifdef BK_SUB_ADDMODE_EN
      r_mode      <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sum    <= sum;
            r_opa    <= opa;
            r_borrow <= 1'b0;
            r_idx    <= '0;
`ifdef BK_SUB_ADDMODE_EN
            r_mode   <= mode;
`endif
          end
        end
        RUN: begin
          r_opb[r_idx*DIGIT +: DIGIT] <= w_dig;
          r_borrow                    <= w_cy;
          r_idx                       <= r_idx + CW'(1);
          if (w_last) r_range_err <= w_err;
        end
        default: ;
      endcase
    end
  end

  assign opb       = r_opb;
  assign range_err = r_range_err;

endmodule

// File: tb/tb_bk_serial_subtractor.sv
// Directed bench for bk_serial_subtractor: hand-computed vectors, latency, backpressure, mid-run reset, back-to-back.
module tb_bk_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [12:0] sum = '0;
  logic [11:0] opa = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] opb;
  logic        range_err;
`ifdef BK_SUB_ADDMODE_EN
  logic        mode = 1'b1;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bk_serial_subtractor #(.WIDTH(12), .DIGIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .opa       (opa),
`ifdef BK_SUB_ADDMODE_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opb       (opb),
    .range_err (range_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where in_ready is seen high.
  task automatic wait_idle(input string tag);
    for (int k = 0; k < 50 && in_ready !== 1'b1; k++) @(negedge clk);
    chk({tag, "_ready_timeout"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [12:0] s, input logic [11:0] a,
                        input logic [11:0] eb, input logic ee, input string tag);
    int   lat;
    logic busy_rdy;
    wait_idle(tag);
    sum = s; opa = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sum = 13'($urandom);
    opa = 12'($urandom);
    lat = 1;
    busy_rdy = 1'b0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) busy_rdy = 1'b1;
    end
    chk({tag, "_latency"}, lat, 32'd7);
    chk({tag, "_busy_ready"}, {31'b0, busy_rdy}, 32'd0);
    @(negedge clk);
    chk({tag, "_opb"}, {20'b0, opb}, {20'b0, eb});
    chk({tag, "_err"}, {31'b0, range_err}, {31'b0, ee});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_post_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  logic [12:0] bs [3];
  logic [11:0] ba [3];
  logic [11:0] bb [3];
  logic        be [3];
  int          acc [3];

  initial begin
    int   k;
    logic seen;

    // Reset state
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_opb", {20'b0, opb}, 32'd0);
    chk("rst_err", {31'b0, range_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(13'h1000, 12'h001, 12'hFFF, 1'b0, "basic");
    run_op(13'h0005, 12'h006, 12'hFFF, 1'b1, "underflow");
    run_op(13'h1FFF, 12'h000, 12'hFFF, 1'b1, "overflow");

    // Backpressure with ignored in_valid pulses
    wait_idle("bp");
    sum = 13'h1FFE; opa = 12'hFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (k = 0; k < 20 && out_valid !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_timeout", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_opb", {20'b0, opb}, 32'hFFF);
      chk("bp_hold_err", {31'b0, range_err}, 32'd0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      in_valid = (i % 2 == 0);
      sum = 13'h0003; opa = 12'h001;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_still_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_keep_opb", {20'b0, opb}, 32'hFFF);
    @(negedge clk);
    chk("bp_no_ghost_op", {31'b0, in_ready}, 32'd1);

    // Reset after E3 aborts the operation
    sum = 13'h0FFF; opa = 12'h0F0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_stale", {31'b0, seen}, 32'd0);
    run_op(13'h0123, 12'h023, 12'h100, 1'b0, "post_rst");

    // Back-to-back with in_valid held high
    bs[0] = 13'h0FFF; ba[0] = 12'h0FF; bb[0] = 12'hF00; be[0] = 1'b0;
    bs[1] = 13'h0000; ba[1] = 12'h001; bb[1] = 12'hFFF; be[1] = 1'b1;
    bs[2] = 13'h1ABC; ba[2] = 12'hCDE; bb[2] = 12'hDDE; be[2] = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sum = bs[i]; opa = ba[i];
      wait_idle("b2b");
      @(posedge clk); #1;
      acc[i] = cyc;
      if (i == 2) in_valid = 1'b0;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (in_ready === 1'b1 && out_valid === 1'b1) seen = 1'b1;
        if (out_valid === 1'b1) break;
      end
      chk("b2b_opb", {20'b0, opb}, {20'b0, bb[i]});
      chk("b2b_err", {31'b0, range_err}, {31'b0, be[i]});
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_overlap", {31'b0, seen}, 32'd0);
    chk("b2b_space01", acc[1] - acc[0], 32'd8);
    chk("b2b_space12", acc[2] - acc[1], 32'd8);
    chk("b2b_final_ready", {31'b0, in_ready}, 32'd1);

`ifdef BK_SUB_ADDMODE_EN
    mode = 1'b0;
    run_op(13'h0FFF, 12'h001, 12'h000, 1'b1, "add_carry");
    run_op(13'h0010, 12'h020, 12'h030, 1'b0, "add_plain");
    mode = 1'b1;
    run_op(13'h1000, 12'h001, 12'hFFF, 1'b0, "sub_again");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bk_serial_subtractor.md
Name: bk_serial_subtractor

Overview:
- Inverse companion of the team's 12-bit Brent-Kung adder.
- Given a (WIDTH+1)-bit sum and one WIDTH-bit operand A, it recovers the other operand B = S − A.
- Digit-serial, DIGIT bits per clock, with a borrow register and a valid/ready handshake on both sides.
- Used in the adder verification and operand-recovery path wherever adder results are unpacked back into operands.

Parameters:
- WIDTH, 12, operand width; the sum is WIDTH+1 bits.
- DIGIT, 2, bits processed per RUN cycle. WIDTH % DIGIT != 0 is an elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sum/opa are valid.
- in_ready  out  1  block can accept an operation.
- sum  in  WIDTH+1  adder result S.
- opa  in  WIDTH  known operand A.
- out_valid  out  1  opb/range_err are valid.
- out_ready  in  1  consumer accepts the result.
- opb  out  WIDTH  recovered operand B = (S − A) mod 2^WIDTH.
- range_err  out  1  S − A does not lie in [0, 2^WIDTH−1].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0, opb=0, range_err=0.
  - Borrow register, digit counter and captured operands cleared.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; no result is ever presented for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge (E0): capture sum and opa, borrow=0, idx=0, state→RUN.
  - in_ready drops after E0.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge computes {borrow', d} = S[idx*DIGIT +: DIGIT] − A[idx*DIGIT +: DIGIT] − borrow.
  - Writes d into opb[idx*DIGIT +: DIGIT], then idx++.
  - After WIDTH/DIGIT edges (E1..E6 at defaults):
    - top = S[WIDTH] − borrow.
    - range_err = (top != 0): top=−1 is underflow, top=+1 is overflow.
    - state→DONE, out_valid=1.
  - Fixed latency: out_valid is seen high after exactly WIDTH/DIGIT+1 edges counting E0 (7 at defaults).
- DONE:
  - out_valid=1; opb and range_err are held stable until out_valid&&out_ready at an edge.
  - On that handshake: state→IDLE, out_valid=0, in_ready=1 from the next cycle. opb and range_err keep their last values.
  - No overlap: a new input is never accepted in the same edge as an output handshake.
- in_valid while busy is ignored; the source must hold it until it sees in_ready.
- The sum and opa inputs may change after E0 without effect.
- Arithmetic is unsigned. opb is always the low WIDTH bits of S − A, including when range_err=1.

Optional Feature:
- Macro: BK_SUB_ADDMODE_EN
- Defined:
  - Adds input port `mode` (1 bit), sampled with the operands at E0.
  - mode=1: subtract, behaves exactly as above.
  - mode=0: add. opb = (S[WIDTH-1:0] + A) mod 2^WIDTH, and the digit register carries a carry instead of a borrow.
  - In add mode, range_err = final carry-out OR S[WIDTH].
  - Latency is identical in both modes.
- Undefined: no `mode` port; always subtract.

Test Plan:
- Reset, then sum=13'h1000, opa=12'h001 → opb=12'hFFF, range_err=0; out_valid high 7 edges after the accept edge.
- sum=13'h0005, opa=12'h006 → opb=12'hFFF, range_err=1 (underflow). Then sum=13'h1FFF, opa=12'h000 → opb=12'hFFF, range_err=1 (overflow).
- Backpressure: sum=13'h1FFE, opa=12'hFFF with out_ready=0 for 5 cycles → opb=12'hFFF, range_err=0 held stable; in_ready stays 0; in_valid pulses with other data are ignored.
- Reset mid-RUN: assert rst_n=0 after E3 → out_valid=0, in_ready=1 immediately. Next op sum=13'h0123, opa=12'h023 → opb=12'h100, range_err=0; no stale result appears.
- Back-to-back: in_valid held high with 3 ops and out_ready=1 → each result is correct; consecutive accepts are spaced 8 edges apart; in_ready never overlaps out_valid.
- With BK_SUB_ADDMODE_EN and mode=0:
  - sum=13'h0FFF, opa=12'h001 → opb=12'h000, range_err=1.
  - sum=13'h0010, opa=12'h020 → opb=12'h030, range_err=0.
